fetch_pc: RTL and testbench
===========================

# fetch_pc

Instruction-fetch front end that owns the program counter. It computes the next PC and issues one instruction-memory request at a time. It returns fetched instructions to decode with a valid/stall handshake. It consumes the branch unit's `pcjump` decision to redirect the PC and squash wrong-path fetches. It sits directly downstream of the branch unit and upstream of decode.

## Interface
- `RESET_PC`, 32'h0000_0000, PC loaded on reset.
- `clk`  in  1  single clock, all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `pcjump`  in  1  redirect request from the branch unit (taken branch or jal/jalr), valid for one cycle.
- `jalr`  in  1  with `pcjump`: target base is `rs1data` instead of `ex_pc`.
- `ex_pc`  in  32  PC of the redirecting instruction.
- `rs1data`  in  32  register operand for jalr.
- `imm`  in  32  sign-extended offset.
- `imem_req`  out  1  request valid.
- `imem_addr`  out  32  request address (= `pc`).
- `imem_ready`  in  1  memory accepts the request this cycle.
- `imem_rvalid`  in  1  response valid (at least 1 cycle after acceptance, in order).
- `imem_rdata`  in  32  response instruction word.
- `if_valid`  out  1  `if_instr`/`if_pc` are valid.
- `if_instr`  out  32  fetched instruction.
- `if_pc`  out  32  address of `if_instr`.
- `if_stall`  in  1  decode cannot accept; hold outputs.
- `misalign`  out  1  sticky: redirect target had bit 1 set; fetch halted until reset.

## Operation
- Target: `jalr` ? ((`rs1data`+`imm`) & ~32'h1) : (`ex_pc`+`imm`). Modulo-2^32 addition, wrap-around allowed.
- Sequential PC: `pc`+4, wrap 32'hFFFF_FFFC -> 32'h0000_0000.
- Fetch state: `outstanding` (0/1), `req_pc`, `discard` flag, 1-entry `hold` buffer (valid, instr, pc), output register.
- `imem_req` = !`misalign` && !`rst` && (`outstanding`==0 || `imem_rvalid`) && !`hold.valid`.
- On accept (`imem_req`&&`imem_ready`): `req_pc`<=`pc`, `pc`<=`pc`+4, `outstanding`<=1.
- Response, `discard`=1: word dropped, `discard`<=0.
- Response, `discard`=0: if output register empty or !`if_stall`, load it (`if_valid`=1, `if_instr`=`imem_rdata`, `if_pc`=`req_pc`); otherwise write to `hold`.
- Output update with !`if_stall`: load from `hold` if valid (then clear it), else from a same-cycle response, else `if_valid`<=0.
- With `if_stall`=1 and `if_valid`=1: outputs held bit-exact.
- Redirect (`pcjump`=1) has priority over all of the above:
  - `pc`<=target.
  - `if_valid`<=0; `hold` cleared.
  - Request still in flight after this cycle, or accepted this cycle: `discard`<=1.
  - `imem_req` forced 0 that cycle.
- Redirect with target[1]=1: `misalign`<=1, `pc`<=target; no further requests issued.
- Redirect while `if_stall`=1: still squashes; `if_stall` does not block flush.
- Simultaneous `imem_rvalid` and `pcjump`: response dropped.

## Timing
- Reset values:
  - `pc`=`RESET_PC`.
  - `imem_req`=0 during reset, asserted the first cycle after `rst` deasserts.
  - `imem_addr`=`RESET_PC`.
  - `if_valid`=0, `if_instr`=0, `if_pc`=0.
  - `misalign`=0.
  - `outstanding`=0, `discard`=0, `hold` empty.
- Reset mid-operation: all state returns to reset values next edge; an in-flight response arriving after reset is ignored because `outstanding`=0.
- Latency: accept at cycle N, `rvalid` at N+1 -> `if_valid` at N+2.
- Throughput: 1 instr/cycle with single-cycle memory and no stall; next request issues in the same cycle a response returns.
- Redirect at cycle N -> `imem_addr`=target with `imem_req`=1 at N+1; first post-redirect `if_valid` at N+3 (single-cycle memory).
- Bounds: at most 1 outstanding request; at most 2 instructions buffered (output register + `hold`).

## Test plan
- Reset, RESET_PC=0x100, memory ready=1 with 1-cycle response -> addresses 0x100, 0x104, 0x108 on consecutive cycles; `if_pc` 0x100, 0x104, 0x108 on consecutive cycles from cycle 2.
- Branch redirect: `pcjump`=1, `ex_pc`=0x200, `imm`=0xFFFFFFF0 while fetch of 0x10C is in flight -> 0x10C word never appears on `if_*`; next `if_pc`=0x1F0.
- jalr: `rs1data`=0x0000_3001, `imm`=4 -> next fetch address 0x3004 (bit 0 cleared). With `imm`=6 -> target 0x3006, `misalign`=1, `imem_req` stays 0 until `rst`.
- Stall: `if_stall`=1 for 5 cycles while the output register and `hold` are full -> outputs constant, `imem_req`=0; on release, `if_pc` sequence has no gap or duplicate.
- Slow memory: `imem_ready` low for 3 cycles, then `rvalid` 4 cycles after accept -> `imem_addr` stable while `imem_req` is held; exactly one instruction is delivered.
- Wrap and reset: PC at 0xFFFF_FFFC -> next address 0x0; assert `rst` with a request outstanding -> late `rvalid` is ignored, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_pc_if.sv
// Fetch-unit bus: branch-unit redirect inputs, instruction-memory request/response
// channel and the instruction stream handed to decode.
//
// Handshakes:
//   imem request : imem_req/imem_addr offered by fetch; the transfer happens on a
//                  rising edge where imem_req && imem_ready.
//   imem response: imem_rvalid/imem_rdata pulse for one cycle per accepted request,
//                  in order, at least one cycle after acceptance; no back-pressure.
//   decode       : if_valid/if_instr/if_pc offered by fetch; decode takes the word on
//                  a rising edge where if_valid && !if_stall, otherwise it stays
//                  held unchanged.
//   redirect     : pcjump is a single-cycle pulse qualified by jalr/ex_pc/rs1data/imm.
interface fetch_pc_if;
  logic        pcjump;
  logic        jalr;
  logic [31:0] ex_pc;
  logic [31:0] rs1data;
  logic [31:0] imm;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_stall;
  logic        misalign;

  modport master (
    input  pcjump, jalr, ex_pc, rs1data, imm,
    output imem_req, imem_addr,
    input  imem_ready, imem_rvalid, imem_rdata,
    output if_valid, if_instr, if_pc,
    input  if_stall,
    output misalign
  );

  modport slave (
    output pcjump, jalr, ex_pc, rs1data, imm,
    input  imem_req, imem_addr,
    output imem_ready, imem_rvalid, imem_rdata,
    input  if_valid, if_instr, if_pc,
    output if_stall,
    input  misalign
  );
endinterface

// File: rtl/fetch_pc.sv
// Instruction-fetch front end: owns the PC, keeps one imem request in flight,
// buffers up to two fetched words (output register + hold) and squashes the
// wrong path on a branch-unit redirect.
module fetch_pc #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic       clk,
  input  logic       rst,
  fetch_pc_if.master bus
);

  logic [31:0] pc;
  logic [31:0] req_pc;
  logic        outstanding;
  logic        discard;
  logic        hold_valid;
  logic [31:0] hold_instr;
  logic [31:0] hold_pc;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        misalign_q;

  logic [31:0] target;
  logic        resp;
  logic        deliver;
  logic        to_hold;
  logic        req;
  logic        accept;

  // Redirect target; jalr clears bit 0 of the computed address.
  always_comb begin
    target = bus.ex_pc + bus.imm;
    if (bus.jalr) target = (bus.rs1data + bus.imm) & ~32'h1;
  end

  // A response only counts while a request is outstanding, so a late word
  // arriving after reset is ignored.
  assign resp    = bus.imem_rvalid && outstanding;
  assign deliver = resp && !discard;
  // A response parked in hold this cycle fills the buffer as surely as an
  // already-valid hold, so it blocks a new request too; otherwise a third word
  // could arrive with nowhere to go.
  assign to_hold = deliver && out_valid && bus.if_stall && !bus.pcjump;
  assign req     = !misalign_q && !rst && !bus.pcjump &&
                   (!outstanding || bus.imem_rvalid) && !hold_valid && !to_hold;
  assign accept  = req && bus.imem_ready;

  assign bus.imem_req  = req;
  assign bus.imem_addr = pc;
  assign bus.if_valid  = out_valid;
  assign bus.if_instr  = out_instr;
  assign bus.if_pc     = out_pc;
  assign bus.misalign  = misalign_q;

  // PC, request tracking, hold buffer and output register; redirect wins over
  // everything except reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      req_pc      <= RESET_PC;
      outstanding <= 1'b0;
      discard     <= 1'b0;
      hold_valid  <= 1'b0;
      hold_instr  <= 32'h0;
      hold_pc     <= 32'h0;
      out_valid   <= 1'b0;
      out_instr   <= 32'h0;
      out_pc      <= 32'h0;
      misalign_q  <= 1'b0;
    end else if (bus.pcjump) begin
      pc          <= target;
      out_valid   <= 1'b0;
      hold_valid  <= 1'b0;
      // A same-cycle response is dropped; a still-pending one must be discarded.
      outstanding <= outstanding && !bus.imem_rvalid;
      discard     <= outstanding && !bus.imem_rvalid;
      if (target[1]) misalign_q <= 1'b1;
    end else begin
      if (accept) begin
        req_pc      <= pc;
        pc          <= pc + 32'd4;
        outstanding <= 1'b1;
      end else if (resp) begin
        outstanding <= 1'b0;
      end
      if (resp && discard) discard <= 1'b0;

      if (!out_valid || !bus.if_stall) begin
        if (hold_valid) begin
          out_valid  <= 1'b1;
          out_instr  <= hold_instr;
          out_pc     <= hold_pc;
          hold_valid <= deliver;
          if (deliver) begin
            hold_instr <= bus.imem_rdata;
            hold_pc    <= req_pc;
          end
        end else if (deliver) begin
          out_valid <= 1'b1;
          out_instr <= bus.imem_rdata;
          out_pc    <= req_pc;
        end else begin
          out_valid <= 1'b0;
        end
      end else if (deliver) begin
        hold_valid <= 1'b1;
        hold_instr <= bus.imem_rdata;
        hold_pc    <= req_pc;
      end
    end
  end

endmodule

// File: tb/tb_fetch_pc.sv
// Bench for fetch_pc: redirect vector table, directed multi-cycle sequences and
// a randomized run against an instruction-stream reference model.
module tb_fetch_pc;
  localparam logic [31:0] RST_PC = 32'h0000_0100;

  typedef struct {
    logic        jalr;
    logic [31:0] ex_pc;
    logic [31:0] rs1;
    logic [31:0] imm;
    logic [31:0] exp_addr;
    logic        exp_mis;
  } redir_vec_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_pc_if bus();
  fetch_pc #(.RESET_PC(RST_PC)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  // memory model state
  logic        pend;
  logic [31:0] pend_addr;
  int          pend_wait;
  bit          mem_auto;
  int          mem_lat;
  logic        acc;
  logic [31:0] acc_addr;

  // scoreboard
  logic [31:0] exp_q[$];
  redir_vec_t  tbl[10];

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic drive_mem();
    if (mem_auto) begin
      if (pend && pend_wait == 0) begin
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = instr_of(pend_addr);
      end else begin
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'hDEAD_BEEF;
      end
    end
  endtask

  // Finish the current cycle: note acceptance, clock edge, memory update, next negedge.
  task automatic step();
    logic rv;
    #1;
    acc      = bus.imem_req && bus.imem_ready;
    acc_addr = bus.imem_addr;
    rv       = bus.imem_rvalid;
    @(posedge clk);
    if (rst) begin
      pend = 1'b0;
    end else begin
      if (rv) pend = 1'b0;
      else if (pend && pend_wait > 0) pend_wait--;
      if (acc) begin
        pend      = 1'b1;
        pend_addr = acc_addr;
        pend_wait = mem_lat - 1;
      end
    end
    @(negedge clk);
    drive_mem();
  endtask

  task automatic idle_inputs();
    bus.pcjump     = 1'b0;
    bus.jalr       = 1'b0;
    bus.ex_pc      = 32'h0;
    bus.rs1data    = 32'h0;
    bus.imm        = 32'h0;
    bus.if_stall   = 1'b0;
    bus.imem_ready = 1'b1;
    mem_auto       = 1'b1;
    mem_lat        = 1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic chk_out(input string name, input logic [31:0] exp_pc);
    chk1({name, "_valid"}, bus.if_valid, 1'b1);
    chk32({name, "_pc"}, bus.if_pc, exp_pc);
    chk32({name, "_instr"}, bus.if_instr, instr_of(exp_pc));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [31:0] first_pc, last_pc, snap_pc, snap_instr, t, e;
    logic        found, got_first, saw_bad, snap_valid;
    logic        r_rst, r_jump, prev_hold, prev_clear;
    logic [31:0] m_pc, hold_pc, hold_instr;
    logic        m_mis;
    int          cnt, consumed;

    tbl[0] = '{1'b0, 32'h0000_0200, 32'h0,         32'hFFFF_FFF0, 32'h0000_01F0, 1'b0};
    tbl[1] = '{1'b1, 32'h0,         32'h0000_3001, 32'h0000_0004, 32'h0000_3004, 1'b0};
    tbl[2] = '{1'b1, 32'h0,         32'h0000_3001, 32'h0000_0006, 32'h0000_3006, 1'b1};
    tbl[3] = '{1'b0, 32'hFFFF_FFF8, 32'h0,         32'h0000_0008, 32'h0000_0000, 1'b0};
    tbl[4] = '{1'b1, 32'h0,         32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0};
    tbl[5] = '{1'b0, 32'h0000_1000, 32'h0,         32'h0000_0002, 32'h0000_1002, 1'b1};
    tbl[6] = '{1'b1, 32'h0000_5000, 32'h0000_0010, 32'hFFFF_FFF0, 32'h0000_0000, 1'b0};
    tbl[7] = '{1'b0, 32'h0000_0400, 32'h0000_8000, 32'h0000_0010, 32'h0000_0410, 1'b0};
    tbl[8] = '{1'b1, 32'h0,         32'h0000_2000, 32'h0000_0009, 32'h0000_2008, 1'b0};
    tbl[9] = '{1'b1, 32'h0,         32'h0000_2000, 32'h0000_0003, 32'h0000_2002, 1'b1};

    rst = 1'b1;
    idle_inputs();
    pend = 1'b0;
    pend_addr = 32'h0;
    pend_wait = 0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 32'h0;
    @(negedge clk);

    // ---- reset values and sequential fetch ----
    step();
    #1;
    chk1("rst_req", bus.imem_req, 1'b0);
    chk32("rst_addr", bus.imem_addr, RST_PC);
    chk1("rst_if_valid", bus.if_valid, 1'b0);
    chk32("rst_if_instr", bus.if_instr, 32'h0);
    chk32("rst_if_pc", bus.if_pc, 32'h0);
    chk1("rst_misalign", bus.misalign, 1'b0);
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (c < 3) begin
        chk1("seq_req", bus.imem_req, 1'b1);
        chk32("seq_addr", bus.imem_addr, RST_PC + 32'(4 * c));
      end
      if (c >= 2) chk_out("seq_out", RST_PC + 32'(4 * (c - 2)));
      step();
    end

    // ---- redirect vector table ----
    for (int i = 0; i < 10; i++) begin
      do_reset();
      step();
      step();
      bus.pcjump  = 1'b1;
      bus.jalr    = tbl[i].jalr;
      bus.ex_pc   = tbl[i].ex_pc;
      bus.rs1data = tbl[i].rs1;
      bus.imm     = tbl[i].imm;
      #1;
      chk1($sformatf("tbl%0d_jump_req", i), bus.imem_req, 1'b0);
      step();
      bus.pcjump = 1'b0;
      #1;
      chk32($sformatf("tbl%0d_addr", i), bus.imem_addr, tbl[i].exp_addr);
      chk1($sformatf("tbl%0d_req", i), bus.imem_req, !tbl[i].exp_mis);
      chk1($sformatf("tbl%0d_mis", i), bus.misalign, tbl[i].exp_mis);
      chk1($sformatf("tbl%0d_squash", i), bus.if_valid, 1'b0);
      step();
      step();
      #1;
      if (tbl[i].exp_mis) begin
        chk1($sformatf("tbl%0d_halt_req", i), bus.imem_req, 1'b0);
        chk1($sformatf("tbl%0d_halt_mis", i), bus.misalign, 1'b1);
        chk1($sformatf("tbl%0d_halt_valid", i), bus.if_valid, 1'b0);
      end else begin
        chk_out($sformatf("tbl%0d_first", i), tbl[i].exp_addr);
      end
    end

    // ---- redirect with a wrong-path fetch in flight ----
    do_reset();
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      #1;
      if (bus.imem_req && bus.imem_addr == 32'h10C) begin
        found = 1'b1;
        mem_lat = 3;
      end
      step();
    end
    chk1("inflight_found_10c", found, 1'b1);
    mem_lat = 1;
    bus.pcjump = 1'b1;
    bus.ex_pc  = 32'h200;
    bus.imm    = 32'hFFFF_FFF0;
    step();
    bus.pcjump = 1'b0;
    got_first = 1'b0;
    saw_bad   = 1'b0;
    first_pc  = 32'h0;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (bus.if_valid) begin
        if (bus.if_pc == 32'h10C) saw_bad = 1'b1;
        if (!got_first) begin
          got_first = 1'b1;
          first_pc  = bus.if_pc;
        end
      end
      step();
    end
    chk1("inflight_no_wrong_path", saw_bad, 1'b0);
    chk32("inflight_first_pc", first_pc, 32'h1F0);

    // ---- stall with output register and hold full ----
    do_reset();
    last_pc = RST_PC - 32'd4;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (bus.if_valid) begin
        chk32("stall_seq_pc", bus.if_pc, last_pc + 32'd4);
        last_pc = bus.if_pc;
      end
      step();
    end
    bus.if_stall = 1'b1;
    #1;
    snap_valid = bus.if_valid;
    snap_pc    = bus.if_pc;
    snap_instr = bus.if_instr;
    chk1("stall_snap_valid", snap_valid, 1'b1);
    step();
    for (int k = 1; k < 5; k++) begin
      #1;
      chk1("stall_req", bus.imem_req, 1'b0);
      chk1("stall_valid", bus.if_valid, 1'b1);
      chk32("stall_pc", bus.if_pc, snap_pc);
      chk32("stall_instr", bus.if_instr, snap_instr);
      step();
    end
    bus.if_stall = 1'b0;
    cnt = 0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (bus.if_valid) begin
        chk32("stall_release_pc", bus.if_pc, last_pc + 32'd4);
        chk32("stall_release_instr", bus.if_instr, instr_of(bus.if_pc));
        last_pc = bus.if_pc;
        cnt++;
      end
      step();
    end
    chk1("stall_release_count", cnt >= 4, 1'b1);

    // ---- slow memory ----
    do_reset();
    bus.imem_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk1("slow_req_held", bus.imem_req, 1'b1);
      chk32("slow_addr_stable", bus.imem_addr, RST_PC);
      step();
    end
    bus.imem_ready = 1'b1;
    mem_lat = 4;
    #1;
    chk32("slow_accept_addr", bus.imem_addr, RST_PC);
    step();
    bus.imem_ready = 1'b0;
    cnt = 0;
    first_pc = 32'h0;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (bus.if_valid) begin
        cnt++;
        first_pc = bus.if_pc;
      end
      step();
    end
    chk32("slow_count", 32'(cnt), 32'd1);
    chk32("slow_pc", first_pc, RST_PC);

    // ---- PC wrap, then reset with a request outstanding ----
    do_reset();
    bus.pcjump = 1'b1;
    bus.ex_pc  = 32'hFFFF_FFF0;
    bus.imm    = 32'h0000_000C;
    step();
    bus.pcjump = 1'b0;
    #1;
    chk32("wrap_addr_top", bus.imem_addr, 32'hFFFF_FFFC);
    chk1("wrap_req_top", bus.imem_req, 1'b1);
    step();
    #1;
    chk32("wrap_addr_zero", bus.imem_addr, 32'h0);
    chk1("wrap_req_zero", bus.imem_req, 1'b1);
    step();
    #1;
    chk_out("wrap_out_top", 32'hFFFF_FFFC);
    step();
    #1;
    chk_out("wrap_out_zero", 32'h0);
    mem_lat = 3;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    mem_auto = 1'b0;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'hBAD0_BAD0;
    bus.imem_ready  = 1'b0;
    #1;
    chk32("late_addr", bus.imem_addr, RST_PC);
    chk1("late_req", bus.imem_req, 1'b1);
    step();
    bus.imem_rvalid = 1'b0;
    #1;
    chk1("late_ignored", bus.if_valid, 1'b0);
    mem_auto = 1'b1;
    bus.imem_ready = 1'b1;
    mem_lat = 1;
    got_first = 1'b0;
    first_pc = 32'h0;
    for (int c = 0; c < 6 && !got_first; c++) begin
      step();
      #1;
      if (bus.if_valid) begin
        got_first = 1'b1;
        first_pc  = bus.if_pc;
        chk32("restart_instr", bus.if_instr, instr_of(RST_PC));
      end
    end
    chk1("restart_seen", got_first, 1'b1);
    chk32("restart_pc", first_pc, RST_PC);

    // ---- randomized run against the instruction-stream model ----
    do_reset();
    m_pc = RST_PC;
    m_mis = 1'b0;
    exp_q.delete();
    prev_hold = 1'b0;
    prev_clear = 1'b1;
    hold_pc = 32'h0;
    hold_instr = 32'h0;
    consumed = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      r_rst  = ($urandom_range(0, 199) == 0) || (m_mis && $urandom_range(0, 7) == 0);
      r_jump = !r_rst && ($urandom_range(0, 11) == 0);
      rst          = r_rst;
      bus.pcjump   = r_jump;
      bus.jalr     = 1'($urandom_range(0, 1));
      bus.ex_pc    = $urandom & ~32'h3;
      bus.rs1data  = ($urandom & ~32'h3) | 32'($urandom_range(0, 1));
      bus.imm      = ($urandom_range(0, 14) == 0) ? (($urandom & ~32'h3) | 32'h2)
                                                  : ($urandom & ~32'h3);
      bus.if_stall   = ($urandom_range(0, 2) == 0);
      bus.imem_ready = ($urandom_range(0, 3) != 0);
      mem_lat        = 32'($urandom_range(1, 3));
      #1;
      chk1("rand_misalign", bus.misalign, m_mis);
      chk32("rand_addr", bus.imem_addr, m_pc);
      if (m_mis || r_rst || r_jump) chk1("rand_req_blocked", bus.imem_req, 1'b0);
      if (prev_clear) chk1("rand_flushed", bus.if_valid, 1'b0);
      if (prev_hold) begin
        chk1("rand_hold_valid", bus.if_valid, 1'b1);
        chk32("rand_hold_pc", bus.if_pc, hold_pc);
        chk32("rand_hold_instr", bus.if_instr, hold_instr);
      end
      if (bus.if_valid && !bus.if_stall && !r_jump && !r_rst) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rand_unexpected: got pc %h expected no instruction", bus.if_pc);
        end else begin
          e = exp_q.pop_front();
          chk32("rand_pc", bus.if_pc, e);
          chk32("rand_instr", bus.if_instr, instr_of(e));
          consumed++;
        end
      end
      prev_hold  = bus.if_valid && bus.if_stall && !r_jump && !r_rst;
      hold_pc    = bus.if_pc;
      hold_instr = bus.if_instr;
      prev_clear = r_rst || r_jump;
      if (bus.jalr) t = (bus.rs1data + bus.imm) & ~32'h1;
      else          t = bus.ex_pc + bus.imm;
      step();
      if (r_rst) begin
        m_pc = RST_PC;
        m_mis = 1'b0;
        exp_q.delete();
      end else if (r_jump) begin
        m_pc = t;
        if (t[1]) m_mis = 1'b1;
        exp_q.delete();
      end else if (acc) begin
        exp_q.push_back(acc_addr);
        m_pc = m_pc + 32'd4;
      end
    end
    rst = 1'b0;
    idle_inputs();
    chk1("rand_progress", consumed > 300, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
